// File: rtl/ssd_debug_pkg.sv
// ssd_debug_pkg
//   Shared definitions for the seven-segment debug scanner:
//   - conv_state_t : states of the sequential binary-to-BCD converter
//   - SEG_DIGITS   : active-low segment patterns for decimal digits 0..9
//   - SEG_DASH     : overflow indicator (segment g only)
//   - SEG_BLANK    : all segments off
//   - seg_decode() : BCD nibble -> active-low segment pattern
//   Segment vectors are ordered {a,b,c,d,e,f,g}, so bit 6 is segment a.
package ssd_debug_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } conv_state_t;

    // Index 0 is the rightmost entry.
    localparam logic [9:0][6:0] SEG_DIGITS = {
        7'h04,  // 9
        7'h00,  // 8
        7'h0F,  // 7
        7'h20,  // 6
        7'h24,  // 5
        7'h4C,  // 4
        7'h06,  // 3
        7'h12,  // 2
        7'h4F,  // 1
        7'h01   // 0
    };

    localparam logic [6:0] SEG_DASH  = 7'h7E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Non-decimal nibbles cannot come out of the converter; show them blank.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (digit <= 4'd9) begin
            seg = SEG_DIGITS[digit];
        end
        return seg;
    endfunction

endpackage

// File: rtl/ssd_debug_scanner_bin2bcd_seq.sv
// bin2bcd_seq
//   Sequential double-dabble converter. A start in IDLE loads the value,
//   then VAL_W add-3/shift iterations build the BCD result, which is valid
//   while done is high (one cycle, DONE state). The value input must stay
//   stable from the start cycle until done.
//   Ports:
//     clk    in   system clock
//     rst    in   synchronous active-low reset
//     start  in   conversion request (taken only when idle)
//     value  in   VAL_W unsigned binary value
//     busy   out  converter not idle
//     done   out  bcd holds the finished result this cycle
//     bcd    out  BCD_DIG packed BCD nibbles, digit 0 in bits [3:0]
module bin2bcd_seq
    import ssd_debug_pkg::*;
#(
    parameter int VAL_W   = 13,
    parameter int BCD_DIG = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [VAL_W-1:0]       value,
    output logic                   busy,
    output logic                   done,
    output logic [4*BCD_DIG-1:0]   bcd
);

    localparam int CNT_W = $clog2(VAL_W + 1);
    localparam int SR_W  = 4 * BCD_DIG + VAL_W;

    conv_state_t          state;
    conv_state_t          state_nxt;
    logic [CNT_W-1:0]     iter;
    logic [SR_W-1:0]      sr_p0;

    function automatic logic [4*BCD_DIG-1:0] dabble(input logic [4*BCD_DIG-1:0] b);
        logic [4*BCD_DIG-1:0] r;
        r = b;
        for (int i = 0; i < BCD_DIG; i++) begin
            if (r[4*i +: 4] >= 4'd5) begin
                r[4*i +: 4] = r[4*i +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = LOAD;
            LOAD:    state_nxt = SHIFT;
            SHIFT:   if (iter == CNT_W'(VAL_W - 1)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            iter <= '0;
        end else if (state == LOAD) begin
            iter <= '0;
        end else if (state == SHIFT) begin
            iter <= iter + 1'b1;
        end
    end

    // Stage p0: shift register, BCD field above the binary field.
    always_ff @(posedge clk) begin
        if (state == LOAD) begin
            sr_p0 <= {{(4*BCD_DIG){1'b0}}, value};
        end else if (state == SHIFT) begin
            sr_p0 <= {dabble(sr_p0[SR_W-1:VAL_W]), sr_p0[VAL_W-1:0]} << 1;
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == DONE);
    assign bcd  = sr_p0[SR_W-1:VAL_W];

endmodule

// File: rtl/ssd_debug_scanner.sv
// ssd_debug_scanner
//   Debug display engine: chooses a probe select (manual or auto-cycling),
//   converts the returned probe value to BCD and multiplexes the digits onto
//   a common-anode seven-segment display.
//   Ports:
//     clk        in   system clock
//     rst        in   synchronous active-low reset
//     auto_en    in   1: auto-cycle probe_sel, 0: follow sel_in
//     sel_in     in   manual probe select
//     probe_val  in   value returned by the core for probe_sel
//     probe_sel  out  select driven to the core
//     anode_n    out  one-hot-low digit enable
//     seg_n      out  segments {a..g}, active-low
//     busy       out  BCD conversion in progress
//     ovf        out  displayed value exceeds NUM_DIGITS decimal digits
//   Build option: define DBG_DISP_LEADING_ZERO_BLANK_EN to blank leading zeros.
module ssd_debug_scanner
    import ssd_debug_pkg::*;
#(
    parameter int VAL_W       = 13,
    parameter int SEL_W       = 4,
    parameter int NUM_SEL     = 16,
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 100000,
    parameter int DWELL_CYC   = 50000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   auto_en,
    input  logic [SEL_W-1:0]       sel_in,
    input  logic [VAL_W-1:0]       probe_val,
    output logic [SEL_W-1:0]       probe_sel,
    output logic [NUM_DIGITS-1:0]  anode_n,
    output logic [6:0]             seg_n,
    output logic                   busy,
    output logic                   ovf
);

    // Converter carries enough nibbles for VAL_W and for every displayed digit.
    localparam int NAT_DIG  = (VAL_W * 3) / 10 + 1;
    localparam int CONV_DIG = (NAT_DIG > NUM_DIGITS) ? NAT_DIG : NUM_DIGITS;
    localparam int DW       = (DWELL_CYC > 1)   ? $clog2(DWELL_CYC)   : 1;
    localparam int RW       = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW       = (NUM_DIGITS > 1)  ? $clog2(NUM_DIGITS)  : 1;

    logic [DW-1:0]              dwell_cnt;
    logic [VAL_W-1:0]           val_p0;
    logic [VAL_W-1:0]           last_val;
    logic [SEL_W-1:0]           last_sel;
    logic                       req;
    logic                       conv_busy;
    logic                       conv_done;
    logic [4*CONV_DIG-1:0]      conv_bcd;
    logic [4*NUM_DIGITS-1:0]    digits;
    logic [4*NUM_DIGITS-1:0]    digits_nxt;
    logic                       ovf_nxt;
    logic                       ovf_show;
    logic [RW-1:0]              refresh_cnt;
    logic [IW-1:0]              idx;
    logic [IW-1:0]              idx_nxt;
    logic [3:0]                 digit_sel;
    logic [NUM_DIGITS-1:0]      anode_nxt;
    logic [6:0]                 seg_nxt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            probe_sel <= '0;
            dwell_cnt <= '0;
        end else if (!auto_en) begin
            probe_sel <= sel_in;
            dwell_cnt <= '0;
        end else if (dwell_cnt == DW'(DWELL_CYC - 1)) begin
            dwell_cnt <= '0;
            probe_sel <= (probe_sel == SEL_W'(NUM_SEL - 1)) ? '0 : probe_sel + 1'b1;
        end else begin
            dwell_cnt <= dwell_cnt + 1'b1;
        end
    end

    // Stage p0: captured probe value; last_val/last_sel record what was sent
    // to the converter, so a change during a conversion stays pending.
    always_ff @(posedge clk) begin
        if (!rst) begin
            val_p0   <= '0;
            last_val <= '0;
            last_sel <= '0;
        end else begin
            val_p0 <= probe_val;
            if (req && !conv_busy) begin
                last_val <= val_p0;
                last_sel <= probe_sel;
            end
        end
    end

    assign req = (val_p0 != last_val) || (probe_sel != last_sel);

    bin2bcd_seq #(
        .VAL_W   (VAL_W),
        .BCD_DIG (CONV_DIG)
    ) u_conv (
        .clk   (clk),
        .rst   (rst),
        .start (req),
        .value (last_val),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    assign busy = conv_busy;

    always_comb begin
        ovf_nxt = 1'b0;
        for (int i = NUM_DIGITS; i < CONV_DIG; i++) begin
            ovf_nxt = ovf_nxt | (conv_bcd[4*i +: 4] != 4'd0);
        end
        digits_nxt = conv_done ? conv_bcd[4*NUM_DIGITS-1:0] : digits;
        ovf_show   = conv_done ? ovf_nxt : ovf;
    end

    always_comb begin
        idx_nxt = idx;
        if (refresh_cnt == RW'(REFRESH_DIV - 1)) begin
            idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
        end
    end

    // Output pins are driven from the next-state digit set and slot so that
    // a DONE coinciding with a slot advance shows the new digits in that slot.
    always_comb begin
        digit_sel = digits_nxt[4*idx_nxt +: 4];
        anode_nxt = ~(NUM_DIGITS'(1) << idx_nxt);
        if (ovf_show) begin
            seg_nxt = SEG_DASH;
        end else begin
            seg_nxt = seg_decode(digit_sel);
`ifdef DBG_DISP_LEADING_ZERO_BLANK_EN
            if ((idx_nxt != '0) && ((digits_nxt >> (4*idx_nxt)) == '0)) begin
                seg_nxt = SEG_BLANK;
            end
`endif
        end
    end

    // Stage p1: display registers, anode and segments change together.
    always_ff @(posedge clk) begin
        if (!rst) begin
            refresh_cnt <= '0;
            idx         <= '0;
            digits      <= '0;
            ovf         <= 1'b0;
            anode_n     <= '1;
            seg_n       <= SEG_BLANK;
        end else begin
            refresh_cnt <= (refresh_cnt == RW'(REFRESH_DIV - 1)) ? '0 : refresh_cnt + 1'b1;
            idx         <= idx_nxt;
            digits      <= digits_nxt;
            ovf         <= ovf_show;
            anode_n     <= anode_nxt;
            seg_n       <= seg_nxt;
        end
    end

endmodule

// File: tb/tb_ssd_debug_scanner.sv
// tb_ssd_debug_scanner
//   Directed bench for ssd_debug_scanner (REFRESH_DIV=4, DWELL_CYC=8, NUM_SEL=3).
//   A cycle-level reference model derived from the display rules is checked
//   against the 4-digit instance every cycle; a 3-digit instance covers overflow.
module tb_ssd_debug_scanner;

    localparam int VAL_W = 13;
    localparam int SEL_W = 4;
    localparam int NSEL  = 3;
    localparam int ND    = 4;
    localparam int RDIV  = 4;
    localparam int DWELL = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             auto_en = 1'b0;
    logic [SEL_W-1:0] sel_in = '0;
    logic [VAL_W-1:0] probe_val = '0;

    logic [SEL_W-1:0] probe_sel;
    logic [ND-1:0]    anode_n;
    logic [6:0]       seg_n;
    logic             busy;
    logic             ovf;

    logic [SEL_W-1:0] probe_sel3;
    logic [2:0]       anode_n3;
    logic [6:0]       seg_n3;
    logic             busy3;
    logic             ovf3;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    ssd_debug_scanner #(
        .VAL_W(VAL_W), .SEL_W(SEL_W), .NUM_SEL(NSEL), .NUM_DIGITS(ND),
        .REFRESH_DIV(RDIV), .DWELL_CYC(DWELL)
    ) u_dut (
        .clk(clk), .rst(rst), .auto_en(auto_en), .sel_in(sel_in),
        .probe_val(probe_val), .probe_sel(probe_sel), .anode_n(anode_n),
        .seg_n(seg_n), .busy(busy), .ovf(ovf)
    );

    ssd_debug_scanner #(
        .VAL_W(VAL_W), .SEL_W(SEL_W), .NUM_SEL(NSEL), .NUM_DIGITS(3),
        .REFRESH_DIV(RDIV), .DWELL_CYC(DWELL)
    ) u_nd3 (
        .clk(clk), .rst(rst), .auto_en(auto_en), .sel_in(sel_in),
        .probe_val(probe_val), .probe_sel(probe_sel3), .anode_n(anode_n3),
        .seg_n(seg_n3), .busy(busy3), .ovf(ovf3)
    );

    // Seven-segment truth table, {a..g} active-low.
    logic [6:0] seg_tab [10] = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C,
                                 7'h24, 7'h20, 7'h0F, 7'h00, 7'h04};

    // Reference model; values describe the state just after each clock edge.
    bit m_valid = 0;
    bit m_in_rst = 1;
    int m_n = 0;           // active edges since reset
    int m_start = 0;       // edge a conversion was accepted
    int m_done = 0;        // edge its result reaches the display
    int m_cap = 0;         // probe_val captured at the previous edge
    int m_last_v = 0;
    int m_last_s = 0;
    int m_conv = 0;
    int m_sel = 0;
    int m_auto_run = 0;
    int m_shown = 0;
    bit m_ovf = 0;

    always @(posedge clk) begin
        m_valid = 1;
        if (!rst) begin
            m_in_rst = 1; m_n = 0; m_start = 0; m_done = 0; m_cap = 0;
            m_last_v = 0; m_last_s = 0; m_conv = 0; m_sel = 0;
            m_auto_run = 0; m_shown = 0; m_ovf = 0;
        end else begin
            m_in_rst = 0;
            m_n++;
            if (m_n == m_done) begin
                m_shown = m_conv;
                m_ovf   = (m_conv > 10**ND - 1);
            end
            if (m_n > m_done && (m_cap != m_last_v || m_sel != m_last_s)) begin
                m_conv   = m_cap;
                m_last_v = m_cap;
                m_last_s = m_sel;
                m_start  = m_n;
                m_done   = m_n + VAL_W + 2;
            end
            m_cap = int'(probe_val);
            if (auto_en) begin
                m_auto_run++;
                if (m_auto_run % DWELL == 0) m_sel = (m_sel == NSEL - 1) ? 0 : m_sel + 1;
            end else begin
                m_auto_run = 0;
                m_sel = int'(sel_in);
            end
        end
    end

    function automatic logic [6:0] exp_seg(input int slot);
        int q;
        q = m_shown;
        for (int i = 0; i < slot; i++) q = q / 10;
        if (m_in_rst) return 7'h7F;
        if (m_ovf) return 7'h7E;
`ifdef DBG_DISP_LEADING_ZERO_BLANK_EN
        if (slot > 0 && q == 0) return 7'h7F;
`endif
        return seg_tab[q % 10];
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            int         slot;
            logic [3:0] e_an;
            logic [6:0] e_seg;
            logic       e_busy;
            slot   = (m_n / RDIV) % ND;
            e_an   = m_in_rst ? 4'hF : ~(4'b0001 << slot);
            e_seg  = exp_seg(slot);
            e_busy = !m_in_rst && (m_start > 0) && (m_n >= m_start) && (m_n < m_done);
            vectors++;
            if (probe_sel !== SEL_W'(m_sel) || busy !== e_busy || ovf !== m_ovf ||
                anode_n !== e_an || seg_n !== e_seg) begin
                errors++;
                $display("FAIL model t=%0t: sel=%0d busy=%b ovf=%b anode_n=%b seg_n=%b, required sel=%0d busy=%b ovf=%b anode_n=%b seg_n=%b",
                         $time, probe_sel, busy, ovf, anode_n, seg_n,
                         m_sel, e_busy, m_ovf, e_an, e_seg);
            end
        end
    end

    task automatic check_bit(input string nm, input logic act, input logic req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %b, required %b", nm, act, req);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int req);
        vectors++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    // Waits (bounded) for digit slot s to be enabled, then checks its segments.
    task automatic check_slot(input string nm, input int s, input logic [6:0] req);
        bit         found;
        logic [3:0] want_an;
        found   = 0;
        want_an = ~(4'b0001 << s);
        for (int i = 0; i < 3 * RDIV * ND && !found; i++) begin
            @(negedge clk);
            if (anode_n === want_an) found = 1;
        end
        vectors++;
        if (!found) begin
            errors++;
            $display("FAIL %s: slot %0d never enabled, anode_n=%b", nm, s, anode_n);
        end else if (seg_n !== req) begin
            errors++;
            $display("FAIL %s: slot %0d seg_n=%b, required %b", nm, s, seg_n, req);
        end
    endtask

    task automatic cycles(input int k);
        repeat (k) @(negedge clk);
    endtask

    logic [6:0] zero_or_blank;
    int         busy_cnt;
    int         rises;
    logic       prev_busy;

    initial begin
`ifdef DBG_DISP_LEADING_ZERO_BLANK_EN
        zero_or_blank = 7'h7F;
`else
        zero_or_blank = 7'h01;
`endif
        // Reset held for two edges.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_int("reset anode_n", int'(anode_n), 'hF);
        check_int("reset seg_n", int'(seg_n), 'h7F);
        check_int("reset probe_sel", int'(probe_sel), 0);
        check_bit("reset busy", busy, 1'b0);
        rst = 1'b1;
        cycles(3);

        // Manual select 2, value 1234.
        sel_in = 4'd2;
        probe_val = 13'd1234;
        busy_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check_int("1234 probe_sel", int'(probe_sel), 2);
        check_int("1234 busy cycles", busy_cnt, 15);
        check_slot("1234 digit0", 0, 7'b1001100);
        check_slot("1234 digit1", 1, 7'h06);
        check_slot("1234 digit2", 2, 7'h12);
        check_slot("1234 digit3", 3, 7'h4F);

        // Largest 13-bit value: fits 4 digits, overflows 3.
        probe_val = 13'd8191;
        cycles(40);
        check_bit("8191 ovf 4-digit", ovf, 1'b0);
        check_bit("8191 ovf 3-digit", ovf3, 1'b1);
        check_int("8191 dash 3-digit", int'(seg_n3), 'h7E);
        check_slot("8191 digit0", 0, 7'h4F);
        check_slot("8191 digit1", 1, 7'h04);
        check_slot("8191 digit2", 2, 7'h4F);
        check_slot("8191 digit3", 3, 7'h00);

        // Change during a conversion: two back-to-back conversions.
        probe_val = 13'd100;
        rises = 0;
        prev_busy = busy;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (i == 2) probe_val = 13'd57;
            if (busy && !prev_busy) rises++;
            prev_busy = busy;
        end
        check_int("100->57 conversions", rises, 2);
        check_slot("57 digit0", 0, 7'h0F);
        check_slot("57 digit1", 1, 7'h24);
        check_slot("57 digit2", 2, zero_or_blank);

        // Auto-scan from select 0.
        sel_in = 4'd0;
        cycles(40);
        auto_en = 1'b1;
        repeat (DWELL) @(posedge clk);
        @(negedge clk);
        check_int("auto sel step1", int'(probe_sel), 1);
        repeat (DWELL) @(posedge clk);
        @(negedge clk);
        check_int("auto sel step2", int'(probe_sel), 2);
        repeat (DWELL) @(posedge clk);
        @(negedge clk);
        check_int("auto sel wrap", int'(probe_sel), 0);

        // Single-digit value, leading-zero handling.
        auto_en = 1'b0;
        probe_val = 13'd7;
        cycles(60);
        check_slot("7 digit0", 0, 7'h0F);
        check_slot("7 digit1", 1, zero_or_blank);
        check_slot("7 digit3", 3, zero_or_blank);

        // Reset in the middle of a conversion.
        probe_val = 13'd1234;
        cycles(6);
        check_bit("busy before reset", busy, 1'b1);
        rst = 1'b0;
        cycles(2);
        check_bit("mid reset busy", busy, 1'b0);
        check_int("mid reset anode_n", int'(anode_n), 'hF);
        check_int("mid reset seg_n", int'(seg_n), 'h7F);
        rst = 1'b1;
        cycles(40);
        check_slot("post reset digit0", 0, 7'b1001100);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
